// File: rtl/dff_arb_pkg.sv
// Shared types and default sizing for the dff write arbiter.
package dff_arb_pkg;
  localparam int DEF_N         = 16;
  localparam int DEF_R         = 4;
  localparam int DEF_MAX_BURST = 4;

  typedef enum logic [1:0] {IDLE, GRANT, CLEAR, PRESET} state_e;
endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester at or above ptr_i, wrapping.
module rr_pick #(
  parameter  int R  = 4,
  localparam int PW = (R > 1) ? $clog2(R) : 1
) (
  input  logic [R-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [R-1:0]  win_o,
  output logic          valid_o
);
  logic [PW:0]   sum;
  logic [PW-1:0] idx;

  always_comb begin
    win_o   = '0;
    valid_o = 1'b0;
    sum     = '0;
    idx     = '0;
    for (int k = 0; k < R; k++) begin
      // ptr_i < R and k < R, so a single subtract is enough to wrap
      sum = {1'b0, ptr_i} + (PW+1)'(k);
      if (sum >= (PW+1)'(R)) sum = sum - (PW+1)'(R);
      idx = sum[PW-1:0];
      if (!valid_o && req_i[idx]) begin
        win_o[idx] = 1'b1;
        valid_o    = 1'b1;
      end
    end
  end
endmodule

// File: rtl/dff_arbiter.sv
// Arbitrates R writers, plus clear/preset commands, onto one external dff.
module dff_arbiter
  import dff_arb_pkg::*;
#(
  parameter int N         = DEF_N,
  parameter int R         = DEF_R,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [R-1:0]   req,
  input  logic [R-1:0]   lock,
  input  logic [R*N-1:0] wdata,
  input  logic           clr_req,
  input  logic           set_req,
  output logic [R-1:0]   gnt,
  output logic           dff_en,
  output logic [N-1:0]   dff_d,
  output logic           dff_reset,
  output logic           dff_set,
  output logic           cmd_ack,
  output logic           busy
);
  localparam int OW = (R > 1) ? $clog2(R) : 1;
  localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);

  state_e        state_q, state_d;
  logic [OW-1:0] owner_q, owner_d, ptr_q, ptr_d, ptr_sel, win_idx;
  logic [BW-1:0] burst_q, burst_d;
  logic [R-1:0]  win;
  logic          win_vld, cont, ends_ok;

  always_comb begin
    cont    = (state_q == GRANT) && lock[owner_q] && req[owner_q] && (burst_q < BURST_LAST);
    ends_ok = (state_q == GRANT) && !clr_req && !set_req && !cont;
    // A normally ending grant hands priority to the next index in the same edge
    ptr_sel = ptr_q;
    if (ends_ok) ptr_sel = (owner_q == OW'(R - 1)) ? '0 : owner_q + 1'b1;
  end

  rr_pick #(.R(R)) u_pick (
    .req_i   (req),
    .ptr_i   (ptr_sel),
    .win_o   (win),
    .valid_o (win_vld)
  );

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < R; i++)
      if (win[i]) win_idx = OW'(i);
  end

  always_comb begin
    state_d = IDLE;
    owner_d = owner_q;
    burst_d = '0;
    ptr_d   = ptr_sel;
    if (clr_req)      state_d = CLEAR;
    else if (set_req) state_d = PRESET;
    else if (cont) begin
      state_d = GRANT;
      burst_d = burst_q + 1'b1;
    end else if (win_vld) begin
      state_d = GRANT;
      owner_d = win_idx;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      burst_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      burst_q <= burst_d;
    end
  end

  // Register-only decode: nothing here sees req combinationally
  always_comb begin
    gnt = '0;
    if (state_q == GRANT) gnt[owner_q] = 1'b1;
    dff_en    = (state_q == GRANT);
    dff_d     = (state_q == GRANT) ? wdata[owner_q*N +: N] : '0;
    dff_reset = (state_q == CLEAR);
    dff_set   = (state_q == PRESET);
    cmd_ack   = (state_q == CLEAR) || (state_q == PRESET);
    busy      = (state_q != IDLE);
  end
endmodule

// File: tb/tb_dff_arbiter.sv
// Directed scoreboard bench for dff_arbiter driving a modelled external dff.
module tb_dff_arbiter;
  localparam int N = 16;
  localparam int R = 4;
  localparam int MB = 4;

  logic           clk = 1'b0;
  logic           reset_n;
  logic [R-1:0]   req, lock, gnt;
  logic [R*N-1:0] wdata;
  logic           clr_req, set_req;
  logic           dff_en, dff_reset, dff_set, cmd_ack, busy;
  logic [N-1:0]   dff_d, q;

  dff_arbiter #(.N(N), .R(R), .MAX_BURST(MB)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .lock(lock), .wdata(wdata),
    .clr_req(clr_req), .set_req(set_req), .gnt(gnt), .dff_en(dff_en),
    .dff_d(dff_d), .dff_reset(dff_reset), .dff_set(dff_set),
    .cmd_ack(cmd_ack), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n)       q <= '0;
    else if (dff_reset) q <= '0;
    else if (dff_set)   q <= '1;
    else if (dff_en)    q <= dff_d;
  end

  typedef struct packed {
    logic [R-1:0] gnt;
    logic         en;
    logic [N-1:0] d;
    logic         rst, set, ack, busy;
    logic [N-1:0] q;
  } obs_t;

  typedef struct {
    int   cyc;
    obs_t o;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic obs_t ob(logic [R-1:0] g, logic [N-1:0] d, logic r, logic s, logic [N-1:0] qv);
    obs_t o;
    o.gnt  = g;
    o.en   = (g != '0);
    o.d    = d;
    o.rst  = r;
    o.set  = s;
    o.ack  = r | s;
    o.busy = (g != '0) | r | s;
    o.q    = qv;
    return o;
  endfunction

  task automatic step(input logic rn, input logic [R-1:0] rq, input logic [R-1:0] lk,
                      input logic c, input logic s, input obs_t e);
    exp_t x;
    @(negedge clk);
    reset_n = rn; req = rq; lock = lk; clr_req = c; set_req = s;
    x.cyc = cyc + 1;
    x.o   = e;
    sb.push_back(x);
  endtask

  // Monitor: invariants every cycle, scoreboard entries when their cycle arrives
  initial begin
    obs_t a;
    exp_t e;
    forever begin
      @(negedge clk);
      checks++;
      if (dff_reset && dff_set) begin
        errors++;
        $display("FAIL rst_set_excl cyc=%0d: dff_reset=%b dff_set=%b, required not both 1", cyc, dff_reset, dff_set);
      end
      checks++;
      if (!$onehot0(gnt)) begin
        errors++;
        $display("FAIL gnt_onehot cyc=%0d: gnt=%b, required at most one-hot", cyc, gnt);
      end
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        a = '{gnt, dff_en, dff_d, dff_reset, dff_set, cmd_ack, busy, q};
        checks++;
        if (e.cyc != cyc) begin
          errors++;
          $display("FAIL stale_entry cyc=%0d: entry for cyc %0d never sampled", cyc, e.cyc);
        end else if (a !== e.o) begin
          errors++;
          $display("FAIL out cyc=%0d: got gnt=%b en=%b d=%h rst=%b set=%b ack=%b busy=%b q=%h, need gnt=%b en=%b d=%h rst=%b set=%b ack=%b busy=%b q=%h",
                   cyc, a.gnt, a.en, a.d, a.rst, a.set, a.ack, a.busy, a.q,
                   e.o.gnt, e.o.en, e.o.d, e.o.rst, e.o.set, e.o.ack, e.o.busy, e.o.q);
        end
      end
    end
  end

  task automatic check_zero(input string name);
    logic [R+N+4:0] v;
    v = {gnt, dff_en, dff_d, dff_reset, dff_set, cmd_ack, busy};
    checks++;
    if (v !== '0) begin
      errors++;
      $display("FAIL %s: outputs=%h, required all 0", name, v);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0; req = '0; lock = '0; clr_req = 1'b0; set_req = 1'b0;
    wdata = {16'h3333, 16'h2222, 16'hAAAA, 16'h1111};
    repeat (2) @(negedge clk);
    #1 check_zero("reset_state");

    // Alternating round-robin between requesters 0 and 2
    step(1, 4'b0101, 4'b0000, 0, 0, ob(4'b0001, 16'h1111, 0, 0, 16'h0000));
    step(1, 4'b0101, 4'b0000, 0, 0, ob(4'b0100, 16'h2222, 0, 0, 16'h1111));
    step(1, 4'b0101, 4'b0000, 0, 0, ob(4'b0001, 16'h1111, 0, 0, 16'h2222));
    step(1, 4'b0101, 4'b0000, 0, 0, ob(4'b0100, 16'h2222, 0, 0, 16'h1111));
    step(1, 4'b0000, 4'b0000, 0, 0, ob(4'b0000, 16'h0000, 0, 0, 16'h2222));
    step(1, 4'b0000, 4'b0000, 0, 0, ob(4'b0000, 16'h0000, 0, 0, 16'h2222));

    // Locked burst by requester 1 capped at MAX_BURST, then requester 3 wins
    step(1, 4'b0010, 4'b0010, 0, 0, ob(4'b0010, 16'hAAAA, 0, 0, 16'h2222));
    step(1, 4'b1010, 4'b0010, 0, 0, ob(4'b0010, 16'hAAAA, 0, 0, 16'hAAAA));
    step(1, 4'b1010, 4'b0010, 0, 0, ob(4'b0010, 16'hAAAA, 0, 0, 16'hAAAA));
    step(1, 4'b1010, 4'b0010, 0, 0, ob(4'b0010, 16'hAAAA, 0, 0, 16'hAAAA));
    step(1, 4'b1010, 4'b0010, 0, 0, ob(4'b1000, 16'h3333, 0, 0, 16'hAAAA));

    // New burst by 1, clear pulsed in its 2nd cycle preempts, 1 wins again from ptr 0
    step(1, 4'b1010, 4'b0010, 0, 0, ob(4'b0010, 16'hAAAA, 0, 0, 16'h3333));
    step(1, 4'b1010, 4'b0010, 0, 0, ob(4'b0010, 16'hAAAA, 0, 0, 16'hAAAA));
    step(1, 4'b1010, 4'b0010, 1, 0, ob(4'b0000, 16'h0000, 1, 0, 16'hAAAA));
    step(1, 4'b1010, 4'b0010, 0, 0, ob(4'b0010, 16'hAAAA, 0, 0, 16'h0000));
    step(1, 4'b0000, 4'b0000, 0, 0, ob(4'b0000, 16'h0000, 0, 0, 16'hAAAA));

    // Clear and preset together: clear first, preset follows while held
    step(1, 4'b0000, 4'b0000, 1, 1, ob(4'b0000, 16'h0000, 1, 0, 16'hAAAA));
    step(1, 4'b0000, 4'b0000, 0, 1, ob(4'b0000, 16'h0000, 0, 1, 16'h0000));
    step(1, 4'b0000, 4'b0000, 0, 0, ob(4'b0000, 16'h0000, 0, 0, 16'hFFFF));
    step(1, 4'b0000, 4'b0000, 0, 0, ob(4'b0000, 16'h0000, 0, 0, 16'hFFFF));

    // Burst by 2 (ptr is 2 here), then asynchronous reset between edges
    step(1, 4'b0100, 4'b0100, 0, 0, ob(4'b0100, 16'h2222, 0, 0, 16'hFFFF));
    step(1, 4'b0100, 4'b0100, 0, 0, ob(4'b0100, 16'h2222, 0, 0, 16'h2222));
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1 check_zero("async_reset_mid_grant");

    // After release: ptr restarts at 0 and burst count starts fresh
    step(0, 4'b1010, 4'b0010, 0, 0, ob(4'b0000, 16'h0000, 0, 0, 16'h0000));
    step(1, 4'b1010, 4'b0010, 0, 0, ob(4'b0010, 16'hAAAA, 0, 0, 16'h0000));
    step(1, 4'b1010, 4'b0010, 0, 0, ob(4'b0010, 16'hAAAA, 0, 0, 16'hAAAA));
    step(1, 4'b1010, 4'b0010, 0, 0, ob(4'b0010, 16'hAAAA, 0, 0, 16'hAAAA));
    step(1, 4'b1010, 4'b0010, 0, 0, ob(4'b0010, 16'hAAAA, 0, 0, 16'hAAAA));
    step(1, 4'b1010, 4'b0010, 0, 0, ob(4'b1000, 16'h3333, 0, 0, 16'hAAAA));
    step(1, 4'b0000, 4'b0000, 0, 0, ob(4'b0000, 16'h0000, 0, 0, 16'h3333));

    // Reset then single requester 3 granted right after release
    step(0, 4'b1000, 4'b0000, 0, 0, ob(4'b0000, 16'h0000, 0, 0, 16'h0000));
    step(1, 4'b1000, 4'b0000, 0, 0, ob(4'b1000, 16'h3333, 0, 0, 16'h0000));
    step(1, 4'b0000, 4'b0000, 0, 0, ob(4'b0000, 16'h0000, 0, 0, 16'h3333));

    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
